// File: rtl/alu_exec_unit.sv
// alu_exec_unit: registered execute stage; bit-serial shifts with valid/ready stalls.
//   Inputs:  clk, rst_n (async, active-low), flush, in_valid, alu_op[2:0],
//            op_a/op_b[XLEN-1:0], rd_in[4:0], out_ready
//   Outputs: in_ready, out_valid, result[XLEN-1:0], zero, rd_out[4:0], busy
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic [4:0]      rd_out,
  output logic            busy
);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d, shamt;
  logic [XLEN-1:0] sh_q, sh_d, sh_nxt, alu_res, result_q, result_d;
  logic [4:0] rd_q, rd_d, rd_out_q, rd_out_d;
  logic dir_q, dir_d, out_valid_q, out_valid_d, zero_q, zero_d;
  logic slot_free, acc, start, fin, step, wr;
  assign shamt     = op_b[SHW-1:0];
  assign slot_free = !out_valid_q || out_ready;
  assign in_ready  = (state_q == IDLE) && !flush && slot_free;
  assign acc       = in_valid && in_ready;
  assign start     = acc && (alu_op == 3'b101 || alu_op == 3'b110) && (shamt != '0);
  assign sh_nxt    = dir_q ? (sh_q >> 1) : (sh_q << 1);
  // Final shift waits at cnt==1 if the output slot is still occupied.
  assign fin       = (state_q == SHIFT) && (cnt_q == SHW'(1)) && slot_free && !flush;
  assign step      = (state_q == SHIFT) && (cnt_q > SHW'(1)) && !flush;
  assign wr        = (acc && !start) || fin;
  always_comb begin
    alu_res = '0;
    case (alu_op)
      3'b000:  alu_res = op_a + op_b;
      3'b001:  alu_res = op_a - op_b;
      3'b010:  alu_res = op_a | op_b;
      3'b011:  alu_res = op_a & op_b;
      3'b100:  alu_res = op_a ^ op_b;
      3'b101:  alu_res = op_a << shamt;
      3'b110:  alu_res = op_a >> shamt;
      default: alu_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
    endcase
  end
  always_comb begin
    state_d     = flush ? IDLE : start ? SHIFT : fin ? IDLE : state_q;
    cnt_d       = flush ? '0 : start ? shamt : fin ? '0 : step ? cnt_q - SHW'(1) : cnt_q;
    sh_d        = start ? op_a : step ? sh_nxt : sh_q;
    dir_d       = start ? alu_op[1] : dir_q;
    rd_d        = start ? rd_in : rd_q;
    result_d    = wr ? (fin ? sh_nxt : alu_res) : result_q;
    zero_d      = wr ? (result_d == '0) : zero_q;
    rd_out_d    = wr ? (fin ? rd_q : rd_in) : rd_out_q;
    out_valid_d = flush ? 1'b0 : wr ? 1'b1 : (out_valid_q && !out_ready);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sh_q        <= '0;
      dir_q       <= 1'b0;
      rd_q        <= '0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      rd_out_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      dir_q       <= dir_d;
      rd_q        <= rd_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      rd_out_q    <= rd_out_d;
      out_valid_q <= out_valid_d;
    end
  end
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
  assign rd_out    = rd_out_q;
  assign busy      = state_q != IDLE;
endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage block directly downstream of the ALU control decoder. It consumes the 3-bit alu_op code together with two operands. It produces a registered result, a zero flag for branch resolution, and the destination register tag. Shifts run iteratively at one bit per cycle, so the block uses valid/ready handshakes on both sides to stall the pipeline.

Parameters:
XLEN, 32, operand and result width.
SHW, 5, shift-amount width; shift amount is op_b[SHW-1:0].

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous kill of the in-flight op and the pending output.
in_valid  in  1  upstream holds a valid op.
in_ready  out  1  block accepts the op this cycle.
alu_op  in  3  000 ADD, 001 SUB, 010 OR, 011 AND, 100 XOR, 101 SLL, 110 SRL, 111 SLT (signed).
op_a  in  XLEN  operand A.
op_b  in  XLEN  operand B.
rd_in  in  5  destination register tag.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
result  out  XLEN  registered result.
zero  out  1  result == 0.
rd_out  out  5  tag of the result.
busy  out  1  state != IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid=0, result=0, zero=0, rd_out=0, busy=0; shift counter and shift register cleared. A reset in the middle of a shift abandons the op with no output.
- Accept: transfer occurs when in_valid && in_ready. in_ready = (state==IDLE) && !flush && (!out_valid || out_ready).
- States: IDLE, SHIFT.
- IDLE, non-shift op or shift with shamt==0:
  - Result registered on the accept edge; out_valid=1 on the next cycle (latency 1).
  - Back-to-back accepts allowed while out_ready=1.
- IDLE, SLL/SRL with shamt!=0:
  - Load the shift register with op_a and the counter with shamt; latch the op and rd_in.
  - Go to SHIFT; busy=1.
- SHIFT:
  - Each cycle, shift one bit (SLL left, SRL logical right, zero fill) and decrement the counter.
  - When the counter reaches 1, the final shift writes result, zero and rd_out, and sets out_valid=1.
  - Return to IDLE. Total latency from accept to out_valid = shamt cycles (shamt=31 -> 31 cycles).
  - in_ready=0 throughout.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN with no overflow flag.
  - SLT gives {XLEN-1 zeros, $signed(op_a) < $signed(op_b)}.
  - zero = (result == 0) and is registered with result.
- Output hold: while out_valid && !out_ready, result, zero and rd_out stay stable. out_valid drops after an out_ready handshake unless a new result is written in the same edge.
- SHIFT completion while the previous output is still stalled: SHIFT is only entered when the output slot will be free, because accept requires !out_valid || out_ready. If out_valid is still 1 at completion, the block stays in SHIFT with counter=1 until out_ready.
- Flush:
  - Next edge: out_valid=0 and state=IDLE; any shift is discarded.
  - flush with in_valid in the same cycle: no accept.
  - flush has priority over out_ready.
- Undefined alu_op is not possible (3-bit encoding fully used).

Test Plan:
- ADD: op_a=0x7FFFFFFF, op_b=1, rd=3, out_ready=1 -> next cycle out_valid=1, result=0x80000000, zero=0, rd_out=3.
- SUB for branch: op_a=op_b=0x1234 -> result=0, zero=1 after 1 cycle. Back-to-back XOR 0xF0F0^0x0FF0 on the next cycle -> 0xFF00.
- SLL: op_a=1, op_b=31 -> in_ready=0 and busy=1 for the shift; out_valid rises exactly 31 cycles after accept, result=0x80000000. SRL with op_b=0x20 (shamt 0) -> 1-cycle result equal to op_a.
- SLT: op_a=0xFFFFFFFF (-1), op_b=1 -> result=1. Swapped operands -> result=0, zero=1.
- Backpressure: out_ready=0 for 5 cycles after an ADD result -> result stable, in_ready=0. out_ready=1 -> one handshake, then a new accept.
- Flush at SHIFT cycle 4 of SLL by 10 -> no out_valid, state IDLE next cycle. rst_n low mid-shift -> all outputs 0 immediately.
